usb_result_tx: RTL

//   Transmit side of the cnn_top USB byte link. Takes one classification result from
//   the inference core: winning class plus NUM_CLASSES raw scores. Serialises it as a

---
 rtl/usb_result_tx.sv | 119 +++++++++++
 1 files changed

// File: rtl/usb_result_tx.sv
// Serialises one classification result (class + scores) into a checksummed byte frame for the host link.
// Header byte appears the cycle after acceptance; each byte is held until the host acks it.
module usb_result_tx #(
    parameter int          NUM_CLASSES = 10,
    parameter int          SCORE_W     = 16,
    parameter logic [7:0]  HDR_BYTE    = 8'hA5
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           result_valid,
    output logic                           result_ready,
    input  logic [3:0]                     result_class,
    input  logic [NUM_CLASSES*SCORE_W-1:0] result_scores,
    output logic [7:0]                     usb_data_out,
    output logic                           usb_data_ready,
    input  logic                           usb_tx_ack,
    output logic                           busy,
    output logic [15:0]                    frames_sent
);

    localparam int BPS   = SCORE_W / 8;
    localparam int NB    = NUM_CLASSES * BPS;
    localparam int CW    = $clog2(NB + 1);
    localparam int DEPTH = 1 << CW;
    localparam logic [CW-1:0] LAST = CW'(NB - 1);

    typedef enum logic [2:0] {IDLE, HDR, CLS, SCORE, CSUM} state_t;

    state_t         state;
    logic [7:0]     sbytes [DEPTH];
    logic [3:0]     cls;
    logic [7:0]     csum;
    logic [CW-1:0]  cnt;
    logic [CW-1:0]  nxt;
    logic           hs;
    logic           accept;

    assign hs     = usb_data_ready && usb_tx_ack;
    assign accept = result_valid && result_ready;
    assign nxt    = cnt + CW'(1);

    // Scores are flattened into wire order (MSB byte of each score first) at acceptance.
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int i = 0; i < NUM_CLASSES; i++) begin
                for (int j = 0; j < BPS; j++) begin
                    sbytes[CW'(i*BPS + j)] <= result_scores[i*SCORE_W + (BPS-1-j)*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            usb_data_out   <= '0;
            usb_data_ready <= 1'b0;
            busy           <= 1'b0;
            frames_sent    <= '0;
            result_ready   <= 1'b0;
            cls            <= '0;
            csum           <= '0;
            cnt            <= '0;
        end else begin
            case (state)
                IDLE: begin
                    result_ready <= 1'b1;
                    if (accept) begin
                        cls            <= result_class;
                        csum           <= '0;
                        cnt            <= '0;
                        usb_data_out   <= HDR_BYTE;
                        usb_data_ready <= 1'b1;
                        busy           <= 1'b1;
                        result_ready   <= 1'b0;
                        state          <= HDR;
                    end
                end
                HDR: begin
                    if (hs) begin
                        usb_data_out <= {4'h0, cls};
                        state        <= CLS;
                    end
                end
                CLS: begin
                    if (hs) begin
                        csum         <= csum + usb_data_out;
                        usb_data_out <= sbytes[cnt];
                        state        <= SCORE;
                    end
                end
                SCORE: begin
                    if (hs) begin
                        csum <= csum + usb_data_out;
                        if (cnt == LAST) begin
                            // Final checksum folds in the score byte being consumed now.
                            usb_data_out <= csum + usb_data_out;
                            state        <= CSUM;
                        end else begin
                            cnt          <= nxt;
                            usb_data_out <= sbytes[nxt];
                        end
                    end
                end
                CSUM: begin
                    if (hs) begin
                        usb_data_ready <= 1'b0;
                        busy           <= 1'b0;
                        result_ready   <= 1'b1;
                        frames_sent    <= frames_sent + 16'd1;
                        state          <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
